// File: rtl/fp16_mul_pkg.sv
// Package for the shared FP16 multiplier arbiter.
// Provides the FP16 word type and the format constants used by the
// multiplier datapath.
package fp16_mul_pkg;

    typedef logic [15:0] fp16_t;

    localparam int    FP16_BIAS    = 15;
    localparam int    FP16_EXP_MAX = 30;
    localparam fp16_t FP16_POS_INF = 16'h7C00;

endpackage : fp16_mul_pkg

// File: rtl/fp16_mul_arbiter_fp16_multiplier.sv
// fp16_multiplier: combinational FP16 x FP16 -> FP16 multiply.
// Simplified semantics: an operand with a zero exponent field counts as zero,
// no NaN/subnormal handling, mantissa truncated (no rounding),
// underflow -> +0, overflow -> signed infinity.
// Ports:
//   a, b - FP16 operands
//   p    - FP16 product
module fp16_multiplier
    import fp16_mul_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t p
);

    localparam logic signed [7:0] BIAS_S    = 8'(FP16_BIAS);
    localparam logic signed [7:0] EXP_MAX_S = 8'(FP16_EXP_MAX);

    logic               sign;
    logic [4:0]         ea;
    logic [4:0]         eb;
    logic [21:0]        prod;
    logic               norm_shift;
    logic [9:0]         frac;
    logic signed [7:0]  exp_sum;

    always_comb begin
        sign       = a[15] ^ b[15];
        ea         = a[14:10];
        eb         = b[14:10];
        prod       = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        // Product of two 1.x mantissas lies in [1,4); bit 21 set means >= 2.
        norm_shift = prod[21];
        frac       = norm_shift ? prod[20:11] : prod[19:10];
        exp_sum    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - BIAS_S
                     + $signed({7'b0, norm_shift});
        if (ea == 5'd0 || eb == 5'd0 || exp_sum < 8'sd1) begin
            p = '0;
        end else if (exp_sum > EXP_MAX_S) begin
            p = {sign, FP16_POS_INF[14:0]};
        end else begin
            p = {sign, exp_sum[4:0], frac};
        end
    end

endmodule : fp16_multiplier

// File: rtl/fp16_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - index of the last granted requester; search starts at ptr+1
//   en     - when low no grant is issued
//   gnt    - one-hot grant (or zero)
//   gnt_id - binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    always_comb begin
        logic found;
        int   idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        // Offsets 1..NUM_REQ visit every requester once, the last granted
        // one coming last, which is what gives round-robin fairness.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one fp16_multiplier among NUM_REQ requesters.
// Round-robin grant into an operand register (S1), multiply, result register
// (S2). Each result carries the index of the requester that issued it.
// Optional feature macro: FP16_MUL_ARB_STATS_EN adds the stall_cnt port.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester operand valid
//   req_ready   - per-requester accept (one-hot or zero)
//   req_a/req_b - packed FP16 operands, requester i at [16*i +: 16]
//   rsp_valid   - result valid;  rsp_ready - consumer accepts result
//   rsp_id      - requester index of the result
//   rsp_result  - FP16 product
//   stall_cnt   - saturating count of cycles with rsp_valid && !rsp_ready
module fp16_mul_arbiter
    import fp16_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_result
`ifdef FP16_MUL_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    fp16_t op_a [NUM_REQ];
    fp16_t op_b [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[16*gi +: 16];
            assign op_b[gi] = req_b[16*gi +: 16];
        end
    endgenerate

    logic              s1_vld_reg;
    fp16_t             s1_a_reg;
    fp16_t             s1_b_reg;
    logic [ID_W-1:0]   s1_id_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic              s2_vld_reg;
    logic [ID_W-1:0]   s2_id_reg;
    fp16_t             s2_result_reg;

    logic              s1_en;
    logic              s2_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_vld;
    fp16_t             mul_p;

    // S2 moves when empty or being drained; S1 moves when empty or S2 moves,
    // so a bubble in S1 is refilled even while S2 is stalled.
    assign s2_en   = !s2_vld_reg || rsp_ready;
    assign s1_en   = !s1_vld_reg || s2_en;
    assign gnt_vld = |gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr_reg),
        .en     (s1_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Gating with rst_n makes req_ready fall the instant reset asserts,
    // rather than re-granting from the freshly cleared (empty) pipeline.
    assign req_ready = gnt & {NUM_REQ{rst_n}};

    fp16_multiplier u_fp16_multiplier (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .p (mul_p)
    );

    // S1: operand register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg <= 1'b0;
            s1_a_reg   <= '0;
            s1_b_reg   <= '0;
            s1_id_reg  <= '0;
            rr_ptr_reg <= ID_W'(NUM_REQ - 1);
        end else if (s1_en) begin
            s1_vld_reg <= gnt_vld;
            if (gnt_vld) begin
                s1_a_reg   <= op_a[gnt_id];
                s1_b_reg   <= op_b[gnt_id];
                s1_id_reg  <= gnt_id;
                rr_ptr_reg <= gnt_id;
            end
        end
    end

    // S2: result register; payload only captured from a valid S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_reg    <= 1'b0;
            s2_id_reg     <= '0;
            s2_result_reg <= '0;
        end else if (s2_en) begin
            s2_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                s2_id_reg     <= s1_id_reg;
                s2_result_reg <= mul_p;
            end
        end
    end

    assign rsp_valid  = s2_vld_reg;
    assign rsp_id     = s2_id_reg;
    assign rsp_result = s2_result_reg;

`ifdef FP16_MUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (s2_vld_reg && !rsp_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule : fp16_mul_arbiter
